uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
- Parametrised UART transmitter and the next generation of the board's fixed 8E1 transmitter.
- Configurable data width, parity mode, stop-bit count and baud divisor.
- Data is sent LSB-first per standard UART, so no bit reversal is needed upstream.
- A small input FIFO with a valid/ready handshake lets the host/ARM bridge queue bytes; queued frames go out back-to-back with no idle gap.

Parameters:
- CLKS_PER_BIT, 1667: clk cycles per bit (16 MHz / 9600); legal >= 4.
- DATA_BITS, 8: data bits per frame; legal 5..9.
- PARITY, 1: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: legal 1 or 2.
- FIFO_DEPTH, 4: input FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- tx_data  in  DATA_BITS  word to transmit
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  FIFO can accept a word (not full)
- tx_out  out  1  serial line; idle high
- busy  out  1  FIFO non-empty or frame in progress
- fifo_level  out  clog2(FIFO_DEPTH)+1  number of words queued, excluding the frame in flight

Behaviour:
- Reset is synchronous, active-high on rst, clocked by clk.
  - Values while and after reset: tx_out = 1, busy = 0, fifo_level = 0, tx_ready = 1, FSM = IDLE, baud counter = 0, bit index = 0.
  - Reset mid-frame aborts the frame and clears the FIFO; tx_out is 1 from the first edge with rst high.
- Push: a word is written when tx_valid && tx_ready at a rising edge.
  - tx_ready = !(fifo_level == FIFO_DEPTH), decoded from registered count.
  - A pop in the same cycle does NOT make a full FIFO accept that cycle.
- Pop: the FSM pops in IDLE when the FIFO is non-empty, or at the end of the final stop bit when the FIFO is non-empty.
  - Simultaneous push and pop: fifo_level unchanged, both words correct.
- FIFO pointers wrap modulo FIFO_DEPTH. Pushing when full is impossible by handshake; a push with tx_ready low is ignored.
- FSM states, with all outputs registered:
  - IDLE: tx_out = 1. If FIFO non-empty: pop into shift register, compute parity, go to START.
  - START: tx_out = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx_out = shift[0]; shift right every CLKS_PER_BIT cycles. After DATA_BITS bits, go to PARITY if PARITY != 0, else STOP.
  - PARITY: tx_out = even: XOR of data bits; odd: its inverse. Held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx_out = 1 for STOP_BITS*CLKS_PER_BIT cycles. At the last cycle: if FIFO non-empty, pop and go directly to START (zero gap); else go to IDLE.
- Parity is computed from the popped word at pop time; later FIFO activity does not affect the frame in flight.
- Baud counter runs 0..CLKS_PER_BIT-1 in every non-IDLE state and resets to 0 on each state/bit change.
  - Every bit is exactly CLKS_PER_BIT cycles; there is no off-by-one on the first or last bit.
- Latency: word pushed into an empty FIFO on edge N while IDLE -> tx_out falls at edge N+2 (FIFO write at N, pop/START at N+1, registered line at N+2). The fixed latency is 2 cycles.
- Frame length is (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
- busy = (state != IDLE) || (fifo_level != 0), registered. It deasserts the cycle after the last stop-bit cycle when nothing is queued.
- tx_data bits above DATA_BITS do not exist; there is no truncation logic.

Test Plan:
- Default params with CLKS_PER_BIT=16: push 0xA5 -> tx_out sequence 0,1,0,1,0,0,1,0,1,0(parity even),1. Each bit 16 cycles; busy high for 176 cycles; then IDLE with tx_out=1.
- PARITY=2, DATA_BITS=7, STOP_BITS=2: push 0x07 -> 0,1,1,1,0,0,0,0, parity 0, 1,1. Frame is 11*16 = 176 cycles.
- PARITY=0: push 0x00, 0xFF, 0x3C in consecutive cycles -> three 10-bit frames back-to-back, no high gap between stop and next start. Total 480 cycles from the first start edge; fifo_level goes 1,2 then drains.
- FIFO_DEPTH=4: hold tx_valid for 6 words while the first frame sends -> tx_ready low once fifo_level=4. Words 1..5 are sent in order; word 6 is accepted only after the next pop.
- Push and pop in the same cycle while fifo_level=2 -> fifo_level stays 2, no word lost or duplicated (check by decoded byte order).
- Assert rst for 1 cycle mid-DATA of 0x55 with 2 words queued -> tx_out=1 next edge, busy=0, fifo_level=0, tx_ready=1. No further frames are sent; a new push afterwards transmits normally.

Source files
------------

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: host-side handshake and status bundle for uart_tx_param.
//   tx_data    word to queue (DATA_BITS wide)
//   tx_valid   tx_data is valid this cycle
//   tx_ready   transmitter FIFO can take a word
//   tx_out     serial line, idle high
//   busy       FIFO non-empty or frame in progress
//   fifo_level words queued, not counting the frame in flight
// Modports: master = host/bridge side, slave = transmitter side.
interface uart_tx_param_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_out;
  logic                 busy;
  logic [LVL_W-1:0]     fifo_level;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_out, busy, fifo_level
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_out, busy, fifo_level
  );
endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (LSB first) with an input FIFO.
// Queued words are sent back-to-back; the line returns to idle only when the
// FIFO runs dry.
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset; aborts any frame and empties the FIFO
//   bus  uart_tx_param_if.slave: tx_data/tx_valid in, tx_ready/tx_out/busy/
//        fifo_level out
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 1667,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_param_if.slave bus
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = 4;

  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]  ZERO_LVL  = {LVL_W{1'b0}};
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ZERO  = {BIT_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Parity bit for a word: even = XOR of the data bits, odd = its inverse.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] word);
    logic p;
    p = ^word;
    if (PARITY == 2) begin
      calc_parity = ~p;
    end else begin
      calc_parity = p;
    end
  endfunction

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0]     count_r, count_s;
  logic                 ready_s, empty_s, push_s, pop_s;
  logic [DATA_BITS-1:0] head_s;

  state_t               state_r, state_s;
  logic [BAUD_W-1:0]    baud_r, baud_s;
  logic [BIT_W-1:0]     bit_r, bit_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic                 par_r, par_s;
  logic                 line_s, bit_end_s;
  logic                 tx_out_r, busy_r;

  // Full is decoded from the registered count, so a same-cycle pop never
  // opens a slot in a full FIFO.
  assign ready_s   = (count_r != FULL_LVL);
  assign empty_s   = (count_r == ZERO_LVL);
  assign push_s    = bus.tx_valid && ready_s;
  assign head_s    = mem_r[rd_ptr_r];
  assign bit_end_s = (baud_r == BAUD_LAST);

  assign bus.tx_ready   = ready_s;
  assign bus.fifo_level = count_r;
  assign bus.tx_out     = tx_out_r;
  assign bus.busy       = busy_r;

  // FIFO storage write; contents need no reset because count_r gates reads.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.tx_data;
    end
  end

  // Next FIFO occupancy from the push/pop pair.
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + LVL_W'(1);
      2'b01:   count_s = count_r - LVL_W'(1);
      default: count_s = count_r;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= ZERO_LVL;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_s;
    end
  end

  // Frame sequencer: next state, baud/bit counters, shift register, pop and
  // the line level belonging to the current state.
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    par_s   = par_r;
    pop_s   = 1'b0;
    line_s  = 1'b1;
    case (state_r)
      ST_IDLE: begin
        line_s = 1'b1;
        baud_s = BAUD_ZERO;
        bit_s  = BIT_ZERO;
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_s = head_s;
          par_s   = calc_parity(head_s);
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        line_s = 1'b0;
        if (bit_end_s) begin
          baud_s  = BAUD_ZERO;
          bit_s   = BIT_ZERO;
          state_s = ST_DATA;
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        line_s = shift_r[0];
        if (bit_end_s) begin
          baud_s  = BAUD_ZERO;
          shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
          if (bit_r == DATA_LAST) begin
            bit_s   = BIT_ZERO;
            state_s = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_s = bit_r + BIT_W'(1);
          end
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end
      ST_PARITY: begin
        line_s = par_r;
        if (bit_end_s) begin
          baud_s  = BAUD_ZERO;
          bit_s   = BIT_ZERO;
          state_s = ST_STOP;
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        line_s = 1'b1;
        if (bit_end_s) begin
          baud_s = BAUD_ZERO;
          if (bit_r == STOP_LAST) begin
            bit_s = BIT_ZERO;
            // Chain straight into the next start bit when a word is waiting.
            if (!empty_s) begin
              pop_s   = 1'b1;
              shift_s = head_s;
              par_s   = calc_parity(head_s);
              state_s = ST_START;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            bit_s = bit_r + BIT_W'(1);
          end
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end
      default: begin
        line_s  = 1'b1;
        state_s = ST_IDLE;
        baud_s  = BAUD_ZERO;
        bit_s   = BIT_ZERO;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      baud_r  <= BAUD_ZERO;
      bit_r   <= BIT_ZERO;
      shift_r <= {DATA_BITS{1'b0}};
      par_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      par_r   <= par_s;
    end
  end

  // Registered outputs: the line lags the sequencer state by one cycle, busy
  // tracks the state and occupancy being loaded on this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_out_r <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      tx_out_r <= line_s;
      busy_r   <= (state_s != ST_IDLE) || (count_s != ZERO_LVL);
    end
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed bench for uart_tx_param using three instances:
// A = 8E1, B = 7O2, C = 8N1, all 16 clocks per bit and a 4-deep FIFO.
module tb_uart_tx_param;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   rst_cnt  = 0;
  int   mon_err  = 0;
  logic [7:0] mon_q [$];

  always #5 clk = ~clk;

  uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_a ();
  uart_tx_param_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if_b ();
  uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_c ();

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                  .FIFO_DEPTH(4)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
                  .FIFO_DEPTH(4)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                  .FIFO_DEPTH(4)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  logic [2:0] line_v, busy_v, rdy_v;
  logic [2:0] lvl_v [3];
  assign line_v   = {if_c.tx_out, if_b.tx_out, if_a.tx_out};
  assign busy_v   = {if_c.busy, if_b.busy, if_a.busy};
  assign rdy_v    = {if_c.tx_ready, if_b.tx_ready, if_a.tx_ready};
  assign lvl_v[0] = if_a.fifo_level;
  assign lvl_v[1] = if_b.fifo_level;
  assign lvl_v[2] = if_c.fifo_level;

  // Frame record: expected line bits in transmission order, first bit leftmost.
  typedef struct {
    int         dut;
    logic [8:0] data;
    int         nbits;
    logic [31:0] frame;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int d, input logic [8:0] data, input logic v);
    case (d)
      0:       begin if_a.tx_data = data[7:0]; if_a.tx_valid = v; end
      1:       begin if_b.tx_data = data[6:0]; if_b.tx_valid = v; end
      default: begin if_c.tx_data = data[7:0]; if_c.tx_valid = v; end
    endcase
  endtask

  task automatic wait_idle(input int d, input string name);
    int c;
    c = 0;
    while (busy_v[d] !== 1'b0 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk(name, busy_v[d], 0);
  endtask

  task automatic wait_mon(input int n, input string name);
    int c;
    c = 0;
    while (mon_q.size() < n && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk(name, mon_q.size(), n);
  endtask

  always @(posedge clk) begin
    if (rst) rst_cnt <= rst_cnt + 1;
  end

  // Independent 8E1 receiver on instance A: samples mid-bit, checks framing
  // and even parity, discards any frame that overlapped a reset.
  initial begin : mon_a
    logic [7:0] d;
    logic       ok;
    int         r0;
    forever begin
      @(negedge clk);
      if (if_a.tx_out === 1'b0) begin
        r0 = rst_cnt;
        ok = 1'b1;
        repeat (CPB/2) @(negedge clk);
        if (if_a.tx_out !== 1'b0) ok = 1'b0;
        for (int j = 0; j < 8; j++) begin
          repeat (CPB) @(negedge clk);
          d[j] = if_a.tx_out;
        end
        repeat (CPB) @(negedge clk);
        if (if_a.tx_out !== ^d) ok = 1'b0;
        repeat (CPB) @(negedge clk);
        if (if_a.tx_out !== 1'b1) ok = 1'b0;
        repeat (CPB/2 - 1) @(negedge clk);
        if (rst_cnt == r0) begin
          mon_q.push_back(d);
          if (!ok) mon_err++;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: run still active at 1000000, required to finish earlier");
    $fatal(1);
  end

  initial begin : main
    vec_t        vecs [7];
    int          d, n, cyc, idx, acc_w6, low_cnt, busy_cnt, base;
    logic        acc;
    logic [31:0] cap;
    logic [7:0]  w [6];

    vecs[0] = '{0, 9'h0A5, 11, 32'(11'b0_10100101_0_1)};
    vecs[1] = '{0, 9'h001, 11, 32'(11'b0_10000000_1_1)};
    vecs[2] = '{0, 9'h0FF, 11, 32'(11'b0_11111111_0_1)};
    vecs[3] = '{1, 9'h007, 11, 32'(11'b0_1110000_0_11)};
    vecs[4] = '{1, 9'h041, 11, 32'(11'b0_1000001_1_11)};
    vecs[5] = '{2, 9'h03C, 10, 32'(10'b0_00111100_1)};
    vecs[6] = '{2, 9'h080, 10, 32'(10'b0_00000001_1)};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) set_in(i, 9'd0, 1'b0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d_line", i), line_v[i], 1);
      chk($sformatf("rst%0d_busy", i), busy_v[i], 0);
      chk($sformatf("rst%0d_level", i), lvl_v[i], 0);
      chk($sformatf("rst%0d_ready", i), rdy_v[i], 1);
    end
    rst = 1'b0;
    @(negedge clk);

    // Single frames: latency, bit timing, frame contents, busy window.
    for (int v = 0; v < 7; v++) begin
      d   = vecs[v].dut;
      n   = vecs[v].nbits;
      cap = 32'd0;
      set_in(d, vecs[v].data, 1'b1);
      @(negedge clk);
      set_in(d, 9'd0, 1'b0);
      chk($sformatf("v%0d_level", v), lvl_v[d], 1);
      chk($sformatf("v%0d_busy_rise", v), busy_v[d], 1);
      for (int k = 1; k <= CPB*n + 1; k++) begin
        @(negedge clk);
        if (k == 1) chk($sformatf("v%0d_lat_hold", v), line_v[d], 1);
        if (k == 2) chk($sformatf("v%0d_lat_start", v), line_v[d], 0);
        if (k >= 2 && ((k-2) % CPB) == CPB/2 && ((k-2) / CPB) < n)
          cap = {cap[30:0], line_v[d]};
        if (k == CPB*n) chk($sformatf("v%0d_busy_last", v), busy_v[d], 1);
        if (k == CPB*n + 1) begin
          chk($sformatf("v%0d_busy_fall", v), busy_v[d], 0);
          chk($sformatf("v%0d_idle_line", v), line_v[d], 1);
        end
      end
      chk($sformatf("v%0d_frame", v), cap, vecs[v].frame);
    end

    // 8N1 back-to-back: three words on consecutive edges, no idle gap.
    cap = 32'd0;
    set_in(2, 9'h000, 1'b1);
    @(negedge clk);
    chk("b2b_level0", lvl_v[2], 1);
    set_in(2, 9'h0FF, 1'b1);
    @(negedge clk);
    chk("b2b_level1", lvl_v[2], 1);
    set_in(2, 9'h03C, 1'b1);
    @(negedge clk);
    chk("b2b_level2", lvl_v[2], 2);
    set_in(2, 9'd0, 1'b0);
    for (int k = 3; k <= 482; k++) begin
      @(negedge clk);
      if (((k-2) % CPB) == CPB/2 && ((k-2) / CPB) < 30) cap = {cap[30:0], line_v[2]};
      if (k == 160) chk("b2b_lvl_before_pop", lvl_v[2], 2);
      if (k == 161) chk("b2b_lvl_after_pop", lvl_v[2], 1);
      if (k == 321) chk("b2b_lvl_drained", lvl_v[2], 0);
      if (k == 480) chk("b2b_busy_last", busy_v[2], 1);
      if (k == 481) chk("b2b_busy_fall", busy_v[2], 0);
    end
    chk("b2b_frames", cap, 32'(30'b0_00000000_1_0_11111111_1_0_00111100_1));

    // Hold tx_valid for six words on the 8E1 instance; FIFO fills at four.
    base = mon_q.size();
    w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    idx = 0; cyc = 0; acc_w6 = 0;
    set_in(0, {1'b0, w[0]}, 1'b1);
    while (idx < 6 && cyc < 400) begin
      acc = rdy_v[0];
      @(negedge clk);
      cyc++;
      if (acc) begin
        if (idx == 5) acc_w6 = cyc;
        idx++;
        if (idx < 6) set_in(0, {1'b0, w[idx]}, 1'b1);
        else set_in(0, 9'd0, 1'b0);
      end
      if (cyc == 5) begin
        chk("full_ready", rdy_v[0], 0);
        chk("full_level", lvl_v[0], 4);
      end
    end
    set_in(0, 9'd0, 1'b0);
    chk("w6_accept_edge", acc_w6, 179);
    wait_mon(base + 6, "full_frames");
    for (int i = 0; i < 6; i++)
      chk($sformatf("full_order%0d", i), mon_q[base + i], w[i]);
    wait_idle(0, "full_drain");

    // Push coinciding with the end-of-frame pop while two words are queued.
    base = mon_q.size();
    for (int e = 1; e <= 178; e++) begin
      case (e)
        1:       set_in(0, 9'h0A1, 1'b1);
        2:       set_in(0, 9'h0B2, 1'b1);
        3:       set_in(0, 9'h0C3, 1'b1);
        178:     set_in(0, 9'h0D4, 1'b1);
        default: set_in(0, 9'd0, 1'b0);
      endcase
      @(negedge clk);
      if (e == 2)   chk("pp_lvl_e2", lvl_v[0], 1);
      if (e == 3)   chk("pp_lvl_e3", lvl_v[0], 2);
      if (e == 177) chk("pp_lvl_before", lvl_v[0], 2);
      if (e == 178) chk("pp_lvl_after", lvl_v[0], 2);
    end
    set_in(0, 9'd0, 1'b0);
    wait_mon(base + 4, "pp_frames");
    chk("pp_order0", mon_q[base],     8'hA1);
    chk("pp_order1", mon_q[base + 1], 8'hB2);
    chk("pp_order2", mon_q[base + 2], 8'hC3);
    chk("pp_order3", mon_q[base + 3], 8'hD4);
    wait_idle(0, "pp_drain");

    // One-cycle reset mid-DATA of 0x55 with two words queued.
    base = mon_q.size();
    for (int e = 1; e <= 40; e++) begin
      case (e)
        1:       set_in(0, 9'h055, 1'b1);
        2:       set_in(0, 9'h066, 1'b1);
        3:       set_in(0, 9'h077, 1'b1);
        default: set_in(0, 9'd0, 1'b0);
      endcase
      if (e == 40) rst = 1'b1;
      @(negedge clk);
      if (e == 3)  chk("rst_pre_level", lvl_v[0], 2);
      if (e == 39) chk("rst_pre_line", line_v[0], 0);
    end
    rst = 1'b0;
    chk("rst_mid_line", line_v[0], 1);
    chk("rst_mid_busy", busy_v[0], 0);
    chk("rst_mid_level", lvl_v[0], 0);
    chk("rst_mid_ready", rdy_v[0], 1);
    low_cnt = 0; busy_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (line_v[0] !== 1'b1) low_cnt++;
      if (busy_v[0] !== 1'b0) busy_cnt++;
    end
    chk("rst_quiet_line", low_cnt, 0);
    chk("rst_quiet_busy", busy_cnt, 0);
    chk("rst_no_frames", mon_q.size(), base);
    set_in(0, 9'h0C3, 1'b1);
    @(negedge clk);
    set_in(0, 9'd0, 1'b0);
    wait_mon(base + 1, "rst_after_frames");
    chk("rst_after_word", mon_q[base], 8'hC3);
    wait_idle(0, "rst_after_drain");
    chk("mon_framing_errors", mon_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
